mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 177 +++++++++++++++++
 tb/tb_mem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed RAM plus a small MMIO block (TOHOST / CYCLE / STORES) that serves a core's fetch and data ports.
// Define MEM_RESPONDER_TEXT_WP_EN to write-protect data stores below TEXT_LIMIT.
module mem_responder #(
  parameter int unsigned                 WORD_BITWIDTH     = 32,
  parameter int unsigned                 RAM_ADDR_BITWIDTH = 10,
  parameter logic [WORD_BITWIDTH-1:0]    TEXT_LIMIT        = 32'h0000_1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inst_ce_i,
  input  logic [WORD_BITWIDTH-1:0] inst_addr_i,
  output logic [WORD_BITWIDTH-1:0] inst_o,
  input  logic                     data_ce_i,
  input  logic                     data_we_i,
  input  logic [WORD_BITWIDTH-1:0] data_addr_i,
  input  logic [WORD_BITWIDTH-1:0] data_i,
  output logic [WORD_BITWIDTH-1:0] data_o,
  output logic                     halt_o,
  output logic [WORD_BITWIDTH-1:0] exit_code_o,
  output logic                     err_o
);

  localparam int unsigned RAM_WORDS = 32'd1 << RAM_ADDR_BITWIDTH;
  localparam int unsigned HI_BITS   = WORD_BITWIDTH - RAM_ADDR_BITWIDTH - 32'd2;

  localparam logic [WORD_BITWIDTH-1:0] NOP_INSN  = WORD_BITWIDTH'(32'h0000_0013);
  localparam logic [WORD_BITWIDTH-1:0] MMIO_BASE = WORD_BITWIDTH'(32'hFFFF_0000);
  localparam logic [WORD_BITWIDTH-1:0] ZERO_WORD = {WORD_BITWIDTH{1'b0}};
  localparam logic [WORD_BITWIDTH-1:0] ONE_WORD  = {{(WORD_BITWIDTH-1){1'b0}}, 1'b1};

  localparam logic [1:0] SEL_TOHOST = 2'd0;
  localparam logic [1:0] SEL_CYCLE  = 2'd1;
  localparam logic [1:0] SEL_STORES = 2'd2;

  function automatic logic f_in_ram(input logic [WORD_BITWIDTH-1:0] addr);
    return (addr[WORD_BITWIDTH-1:RAM_ADDR_BITWIDTH+2] == {HI_BITS{1'b0}});
  endfunction

  // Slot 3 of the 16-byte MMIO window is a hole.
  function automatic logic f_in_mmio(input logic [WORD_BITWIDTH-1:0] addr);
    return (addr[WORD_BITWIDTH-1:4] == MMIO_BASE[WORD_BITWIDTH-1:4]) && (addr[3:2] != 2'd3);
  endfunction

  function automatic logic [RAM_ADDR_BITWIDTH-1:0] f_idx(input logic [WORD_BITWIDTH-1:0] addr);
    return addr[RAM_ADDR_BITWIDTH+1:2];
  endfunction

  logic [WORD_BITWIDTH-1:0] r_mem [RAM_WORDS];

  logic                     r_halt;
  logic                     r_err;
  logic [WORD_BITWIDTH-1:0] r_exit;
  logic [WORD_BITWIDTH-1:0] r_cycle;
  logic [WORD_BITWIDTH-1:0] r_stores;

  logic                         w_inst_in_ram;
  logic [RAM_ADDR_BITWIDTH-1:0] w_inst_idx;
  logic                         w_data_in_ram;
  logic                         w_data_in_mmio;
  logic [RAM_ADDR_BITWIDTH-1:0] w_data_idx;
  logic [1:0]                   w_mmio_sel;
  logic                         w_data_access;
  logic                         w_misaligned;
  logic                         w_in_text;
  logic                         w_text_block;
  logic                         w_ram_we;
  logic                         w_tohost_we;
  logic                         w_ro_we;
  logic                         w_err_set;
  logic                         w_unused;
  logic [WORD_BITWIDTH-1:0]     w_inst;
  logic [WORD_BITWIDTH-1:0]     w_rdata;

  assign w_inst_in_ram  = f_in_ram(inst_addr_i);
  assign w_inst_idx     = f_idx(inst_addr_i);
  assign w_data_in_ram  = f_in_ram(data_addr_i);
  assign w_data_in_mmio = f_in_mmio(data_addr_i);
  assign w_data_idx     = f_idx(data_addr_i);
  assign w_mmio_sel     = data_addr_i[3:2];
  assign w_data_access  = data_ce_i | data_we_i;
  assign w_misaligned   = (data_addr_i[1:0] != 2'b00);
  assign w_in_text      = (data_addr_i < TEXT_LIMIT);

`ifdef MEM_RESPONDER_TEXT_WP_EN
  assign w_text_block = w_in_text;
  assign w_unused     = ^inst_addr_i[1:0];
`else
  assign w_text_block = 1'b0;
  assign w_unused     = ^{inst_addr_i[1:0], w_in_text};
`endif

  // Misaligned stores still land in the indexed word; only the error flag records them.
  assign w_ram_we    = data_we_i & w_data_in_ram & ~w_text_block;
  assign w_tohost_we = data_we_i & w_data_in_mmio & (w_mmio_sel == SEL_TOHOST);
  assign w_ro_we     = data_we_i & w_data_in_mmio &
                       ((w_mmio_sel == SEL_CYCLE) | (w_mmio_sel == SEL_STORES));

  assign w_err_set = (w_data_access & (w_misaligned | ~(w_data_in_ram | w_data_in_mmio)))
                   | (inst_ce_i & ~w_inst_in_ram)
                   | w_ro_we
                   | (data_we_i & w_data_in_ram & w_text_block);

  always_comb begin
    w_inst = NOP_INSN;
    if (inst_ce_i && w_inst_in_ram) begin
      w_inst = r_mem[w_inst_idx];
    end else begin
      w_inst = NOP_INSN;
    end
  end

  always_comb begin
    w_rdata = ZERO_WORD;
    if (!data_ce_i) begin
      w_rdata = ZERO_WORD;
    end else if (w_data_in_ram) begin
      w_rdata = r_mem[w_data_idx];
    end else if (w_data_in_mmio) begin
      case (w_mmio_sel)
        SEL_TOHOST: w_rdata = r_exit;
        SEL_CYCLE:  w_rdata = r_cycle;
        SEL_STORES: w_rdata = r_stores;
        default:    w_rdata = ZERO_WORD;
      endcase
    end else begin
      w_rdata = ZERO_WORD;
    end
  end

  // Reset leaves the array untouched but holds off any write while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (w_ram_we) begin
      r_mem[w_data_idx] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle  <= ZERO_WORD;
      r_stores <= ZERO_WORD;
    end else begin
      if (!r_halt) begin
        r_cycle <= r_cycle + ONE_WORD;
      end
      if (w_ram_we) begin
        r_stores <= r_stores + ONE_WORD;
      end
    end
  end

  // Halt and error are sticky until reset; exit code tracks every TOHOST store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halt <= 1'b0;
      r_exit <= ZERO_WORD;
      r_err  <= 1'b0;
    end else begin
      if (w_tohost_we) begin
        r_exit <= data_i;
        if (|data_i) begin
          r_halt <= 1'b1;
        end
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign inst_o      = w_inst;
  assign data_o      = w_rdata;
  assign halt_o      = r_halt;
  assign exit_code_o = r_exit;
  assign err_o       = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a vector table for RAM/fetch traffic plus
// hand sequences for halt, reset, error and text-protection corners.
module tb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        inst_ce_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_o;
  logic        data_ce_i;
  logic        data_we_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        halt_o;
  logic [31:0] exit_code_o;
  logic        err_o;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_cycle = 32'd0;
  logic        exp_halt  = 1'b0;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] TOHOST  = 32'hFFFF_0000;
  localparam logic [31:0] CYCLE   = 32'hFFFF_0004;
  localparam logic [31:0] STORES  = 32'hFFFF_0008;
`ifdef MEM_RESPONDER_TEXT_WP_EN
  localparam logic [31:0] PROG_ADDR = 32'h0000_1000;
`else
  localparam logic [31:0] PROG_ADDR = 32'h0000_0000;
`endif

  mem_responder #(.RAM_ADDR_BITWIDTH(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inst_ce_i   (inst_ce_i),
    .inst_addr_i (inst_addr_i),
    .inst_o      (inst_o),
    .data_ce_i   (data_ce_i),
    .data_we_i   (data_we_i),
    .data_addr_i (data_addr_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .halt_o      (halt_o),
    .exit_code_o (exit_code_o),
    .err_o       (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        ice;
    logic [31:0] iaddr;
    logic        dce;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [31:0] exp_inst;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  // One clock edge, tracking the expected free-running cycle count.
  task automatic step();
    @(posedge clk);
    if (rst_n && !exp_halt) exp_cycle = exp_cycle + 32'd1;
    #1;
  endtask

  task automatic drive(input logic ice, input logic [31:0] ia, input logic dce, input logic dwe,
                       input logic [31:0] da, input logic [31:0] wd);
    inst_ce_i = ice; inst_addr_i = ia;
    data_ce_i = dce; data_we_i = dwe; data_addr_i = da; data_i = wd;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, 32'd0, 1'b1, 1'b0, a, 32'd0);
    #1;
    chk(name, data_o, exp);
  endtask

  task automatic reset_pulse();
    idle();
    rst_n = 1'b0; exp_cycle = 32'd0; exp_halt = 1'b0;
    #1;
    chk("rst_err", {31'd0, err_o}, 32'd0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_halt", {31'd0, halt_o}, 32'd0);
    chk("rst_exit", exit_code_o, 32'd0);
    chk("rst_err",  {31'd0, err_o}, 32'd0);
    step(); step();
    read_chk("rst_cycle", CYCLE, 32'd0);
    rst_n = 1'b1;
    step();
    read_chk("cycle_first", CYCLE, 32'd1);
    step();
    read_chk("cycle_second", CYCLE, 32'd2);

    vecs[0]  = '{"wr_prog",     1'b0, 32'd0,     1'b0, 1'b1, PROG_ADDR,      32'h0050_0093, NOP,           32'd0};
    vecs[1]  = '{"fetch_prog",  1'b1, PROG_ADDR, 1'b0, 1'b0, 32'd0,          32'd0,         32'h0050_0093, 32'd0};
    vecs[2]  = '{"fetch_off",   1'b0, PROG_ADDR, 1'b0, 1'b0, 32'd0,          32'd0,         NOP,           32'd0};
    vecs[3]  = '{"wr_2000_a",   1'b0, 32'd0,     1'b0, 1'b1, 32'h0000_2000,  32'h1111_2222, NOP,           32'd0};
    vecs[4]  = '{"rw_2000_old", 1'b0, 32'd0,     1'b1, 1'b1, 32'h0000_2000,  32'hDEAD_BEEF, NOP,           32'h1111_2222};
    vecs[5]  = '{"rd_2000_new", 1'b0, 32'd0,     1'b1, 1'b0, 32'h0000_2000,  32'd0,         NOP,           32'hDEAD_BEEF};
    vecs[6]  = '{"stores_3",    1'b0, 32'd0,     1'b1, 1'b0, STORES,         32'd0,         NOP,           32'd3};
    vecs[7]  = '{"wr_last",     1'b0, 32'd0,     1'b0, 1'b1, 32'h0000_3FFC,  32'h5A5A_0001, NOP,           32'd0};
    vecs[8]  = '{"rd_last",     1'b1, 32'h3FFC,  1'b1, 1'b0, 32'h0000_3FFC,  32'd0,         32'h5A5A_0001, 32'h5A5A_0001};
    vecs[9]  = '{"stores_4",    1'b0, 32'd0,     1'b1, 1'b0, STORES,         32'd0,         NOP,           32'd4};
    vecs[10] = '{"tohost_0",    1'b0, 32'd0,     1'b1, 1'b0, TOHOST,         32'd0,         NOP,           32'd0};

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].ice, vecs[i].iaddr, vecs[i].dce, vecs[i].dwe, vecs[i].daddr, vecs[i].wdata);
      #1;
      chk({vecs[i].name, "_inst"}, inst_o, vecs[i].exp_inst);
      chk({vecs[i].name, "_data"}, data_o, vecs[i].exp_data);
      step();
      chk({vecs[i].name, "_err"}, {31'd0, err_o}, 32'd0);
    end

    // TOHOST write halts and freezes CYCLE
    drive(1'b0, 32'd0, 1'b0, 1'b1, TOHOST, 32'd1);
    step();
    exp_halt = 1'b1;
    chk("halt_set", {31'd0, halt_o}, 32'd1);
    chk("exit_set", exit_code_o, 32'd1);
    read_chk("cycle_frozen0", CYCLE, exp_cycle);
    step();
    read_chk("cycle_frozen1", CYCLE, exp_cycle);
    step(); step();
    read_chk("cycle_frozen2", CYCLE, exp_cycle);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_2004, 32'h0000_0077);
    step();
    read_chk("post_halt_wr", 32'h0000_2004, 32'h0000_0077);
    read_chk("stores_5", STORES, 32'd5);
    read_chk("tohost_rd", TOHOST, 32'd1);
    chk("no_err_yet", {31'd0, err_o}, 32'd0);

    // read-only MMIO write is dropped and flagged
    drive(1'b0, 32'd0, 1'b0, 1'b1, CYCLE, 32'd5);
    step();
    chk("ro_wr_err", {31'd0, err_o}, 32'd1);
    read_chk("ro_wr_drop", CYCLE, exp_cycle);

    // reset mid-write: state clears at once, RAM kept, write dropped
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_2000, 32'hBAD0_BAD0);
    #1;
    rst_n = 1'b0; exp_cycle = 32'd0; exp_halt = 1'b0;
    #1;
    chk("mid_rst_halt", {31'd0, halt_o}, 32'd0);
    chk("mid_rst_err",  {31'd0, err_o}, 32'd0);
    chk("mid_rst_exit", exit_code_o, 32'd0);
    read_chk("mid_rst_cycle", CYCLE, 32'd0);
    read_chk("mid_rst_stores", STORES, 32'd0);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_2000, 32'hBAD0_BAD0);
    step();
    idle();
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 1'b1, 1'b0, CYCLE, 32'd0);
    step();
    chk("cycle_after_rst", data_o, 32'd1);
    read_chk("ram_kept_2000", 32'h0000_2000, 32'hDEAD_BEEF);
    read_chk("ram_kept_2004", 32'h0000_2004, 32'h0000_0077);

    // misaligned read, unmapped read, misaligned write
    read_chk("misal_rd_data", 32'h0000_2002, 32'hDEAD_BEEF);
    step();
    chk("misal_err", {31'd0, err_o}, 32'd1);
    read_chk("unmap_rd_data", 32'h8000_0000, 32'd0);
    step(); step();
    chk("err_sticky", {31'd0, err_o}, 32'd1);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_2006, 32'h1234_5678);
    step();
    read_chk("misal_wr_commit", 32'h0000_2004, 32'h1234_5678);
    read_chk("misal_wr_stores", STORES, 32'd1);
    reset_pulse();

    // unmapped fetch and unmapped write
    drive(1'b1, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0010, 32'h0000_00FF);
    #1;
    chk("unmap_fetch_nop", inst_o, NOP);
    step();
    chk("unmap_fetch_err", {31'd0, err_o}, 32'd1);
    read_chk("unmap_wr_stores", STORES, 32'd0);
    reset_pulse();

    // text region write
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_AAAA);
    step();
`ifdef MEM_RESPONDER_TEXT_WP_EN
    chk("text_wp_err", {31'd0, err_o}, 32'd1);
    read_chk("text_wp_stores", STORES, 32'd0);
`else
    chk("text_wr_err", {31'd0, err_o}, 32'd0);
    read_chk("text_wr_data", 32'h0000_0010, 32'h0000_AAAA);
    read_chk("text_wr_stores", STORES, 32'd1);
`endif
    reset_pulse();

    // zero to TOHOST records exit code without halting
    drive(1'b0, 32'd0, 1'b0, 1'b1, TOHOST, 32'd0);
    step();
    chk("tohost0_halt", {31'd0, halt_o}, 32'd0);
    drive(1'b0, 32'd0, 1'b0, 1'b1, TOHOST, 32'h0000_002A);
    step();
    chk("tohost2a_halt", {31'd0, halt_o}, 32'd1);
    chk("tohost2a_exit", exit_code_o, 32'h0000_002A);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
